sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter.sv | 122 ++++++++++++
 tb/tb_sram_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// Two-master (fetch/MEM) arbiter onto a single request/response SRAM bus.
// Optional macro ARB_RR_EN: round-robin tie-break instead of fixed DATA priority.
module sram_arbiter #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic [31:0]       inst_rdata,
    output logic              inst_stall,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [3:0]        data_wen,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [31:0]       data_wdata,
    output logic [31:0]       data_rdata,
    output logic              data_stall,
    output logic              bus_req,
    output logic              bus_wr,
    output logic [3:0]        bus_wstrb,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [31:0]       bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [31:0]       bus_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;
    typedef enum logic {OWN_INST, OWN_DATA} own_e;

    state_e            state_q, state_d;
    own_e              own_q;
    logic              bus_req_q, bus_wr_q;
    logic [3:0]        bus_wstrb_q;
    logic [ADDR_W-1:0] bus_addr_q;
    logic [31:0]       bus_wdata_q;
    logic [31:0]       inst_rdata_q, data_rdata_q;
    logic              tie_data, grant_data;

`ifdef ARB_RR_EN
    own_e last_q;
    always_comb tie_data = (last_q == OWN_INST);
`else
    always_comb tie_data = 1'b1;
`endif

    // Winner selection in IDLE and next-state decode.
    always_comb begin
        grant_data = data_req & (~inst_req | tie_data);
        state_d    = state_q;
        case (state_q)
            S_IDLE:  if (inst_req | data_req) state_d = S_REQ;
            S_REQ:   if (bus_addr_ok)         state_d = S_WAIT;
            S_WAIT:  if (bus_data_ok)         state_d = S_DONE;
            S_DONE:                           state_d = S_IDLE;
            default:                          state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            own_q        <= OWN_INST;
            bus_req_q    <= 1'b0;
            bus_wr_q     <= 1'b0;
            bus_wstrb_q  <= 4'h0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= 32'h0;
            inst_rdata_q <= 32'h0;
            data_rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (inst_req | data_req) begin
                        own_q       <= grant_data ? OWN_DATA : OWN_INST;
                        bus_req_q   <= 1'b1;
                        bus_addr_q  <= grant_data ? data_addr : inst_addr;
                        bus_wr_q    <= grant_data & data_wr;
                        bus_wstrb_q <= grant_data ? data_wen : 4'h0;
                        bus_wdata_q <= grant_data ? data_wdata : 32'h0;
                    end
                end
                S_REQ: begin
                    if (bus_addr_ok) bus_req_q <= 1'b0;
                end
                S_WAIT: begin
                    // Writes complete on data_ok but leave the load register alone.
                    if (bus_data_ok) begin
                        if (own_q == OWN_INST)   inst_rdata_q <= bus_rdata;
                        else if (!bus_wr_q)      data_rdata_q <= bus_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ARB_RR_EN
    // Remembers the most recent grant; resets to DATA so the first tie goes to INST.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= OWN_DATA;
        end else if (state_q == S_IDLE && (inst_req | data_req)) begin
            last_q <= grant_data ? OWN_DATA : OWN_INST;
        end
    end
`endif

    assign inst_stall = inst_req & ~(state_q == S_DONE && own_q == OWN_INST);
    assign data_stall = data_req & ~(state_q == S_DONE && own_q == OWN_DATA);

    assign bus_req    = bus_req_q;
    assign bus_wr     = bus_wr_q;
    assign bus_wstrb  = bus_wstrb_q;
    assign bus_addr   = bus_addr_q;
    assign bus_wdata  = bus_wdata_q;
    assign inst_rdata = inst_rdata_q;
    assign data_rdata = data_rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed scenarios plus randomized
// transactions checked against a transaction-level arbitration model.
module tb_sram_arbiter;
    localparam int unsigned ADDR_W = 32;
`ifdef ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              inst_req, data_req, data_wr;
    logic [ADDR_W-1:0] inst_addr, data_addr, bus_addr;
    logic [31:0]       inst_rdata, data_rdata, data_wdata, bus_wdata, bus_rdata;
    logic              inst_stall, data_stall, bus_req, bus_wr, bus_addr_ok, bus_data_ok;
    logic [3:0]        data_wen, bus_wstrb;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: last captured read data per owner and last grant.
    logic [31:0] m_irdata, m_drdata;
    bit          m_last_data;

    sram_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_stall(inst_stall),
        .data_req(data_req), .data_wr(data_wr), .data_wen(data_wen), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_rdata(data_rdata), .data_stall(data_stall),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_wstrb(bus_wstrb), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
        .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset;
        m_irdata    = 32'h0;
        m_drdata    = 32'h0;
        m_last_data = 1'b1;
    endtask

    // One full transaction starting in an IDLE cycle; leaves the loser's request pending.
    task automatic do_txn(input bit ireq, input bit dreq, input bit dwr,
                          input logic [31:0] ia, input logic [31:0] da, input logic [31:0] wd,
                          input logic [31:0] rd, input logic [3:0] wen,
                          input int a_dly, input int d_dly, input bit spur, input bit drop);
        bit          win_d;
        logic [31:0] e_addr;
        logic        e_wr;
        logic [3:0]  e_strb;
        logic [37:0] got, exp;
        if (!inst_req) inst_addr = ia;
        if (!data_req) begin
            data_addr = da; data_wr = dwr; data_wen = wen; data_wdata = wd;
        end
        inst_req = inst_req | ireq;
        data_req = data_req | dreq;
        if (inst_req && data_req) win_d = RR ? !m_last_data : 1'b1;
        else                      win_d = data_req;
        m_last_data = win_d;
        e_addr = win_d ? data_addr : inst_addr;
        e_wr   = win_d && data_wr;
        e_strb = win_d ? data_wen : 4'h0;
        #1;
        n_checks++;
        if (bus_req !== 1'b0 || inst_stall !== inst_req || data_stall !== data_req)
            $display("FAIL idle_cycle: bus_req=%b istall=%b dstall=%b, required 0 %b %b",
                     bus_req, inst_stall, data_stall, inst_req, data_req);
        else n_pass++;
        // Request phase: fields must be stable until addr_ok is accepted.
        for (int c = 0; c <= a_dly; c++) begin
            step;
            bus_addr_ok = (c == a_dly);
            bus_data_ok = spur && (c == 0) && (a_dly > 0);
            bus_rdata   = $urandom;
            #1;
            got = {bus_req, bus_wr, bus_wstrb, bus_addr};
            exp = {1'b1, e_wr, e_strb, e_addr};
            n_checks++;
            if (got !== exp || inst_stall !== inst_req || data_stall !== data_req)
                $display("FAIL req_phase c=%0d: bus=%h stalls=%b%b, required bus=%h stalls=%b%b",
                         c, got, inst_stall, data_stall, exp, inst_req, data_req);
            else n_pass++;
            if (e_wr) begin
                n_checks++;
                if (bus_wdata !== data_wdata)
                    $display("FAIL req_wdata: got %h required %h", bus_wdata, data_wdata);
                else n_pass++;
            end
        end
        // Wait phase: bus_req dropped, stalls held, response after d_dly cycles.
        for (int c = 0; c <= d_dly; c++) begin
            step;
            bus_addr_ok = spur && (c == 0) && (d_dly > 0);
            bus_data_ok = (c == d_dly);
            bus_rdata   = (c == d_dly) ? rd : $urandom;
            if (drop && c == 0) begin
                if (win_d) data_req = 1'b0;
                else       inst_req = 1'b0;
            end
            #1;
            n_checks++;
            if (bus_req !== 1'b0 || inst_stall !== inst_req || data_stall !== data_req)
                $display("FAIL wait_phase c=%0d: bus_req=%b stalls=%b%b, required 0 %b%b",
                         c, bus_req, inst_stall, data_stall, inst_req, data_req);
            else n_pass++;
        end
        // DONE: the winner is released and its read data is visible.
        step;
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
        bus_rdata   = $urandom;
        if (!win_d)     m_irdata = rd;
        else if (!e_wr) m_drdata = rd;
        #1;
        n_checks++;
        if (inst_rdata !== m_irdata || data_rdata !== m_drdata)
            $display("FAIL done_rdata: inst=%h data=%h, required inst=%h data=%h",
                     inst_rdata, data_rdata, m_irdata, m_drdata);
        else n_pass++;
        n_checks++;
        if (inst_stall !== (win_d ? inst_req : 1'b0) || data_stall !== (win_d ? 1'b0 : data_req)
            || bus_req !== 1'b0)
            $display("FAIL done_stall: stalls=%b%b bus_req=%b, required %b%b 0", inst_stall,
                     data_stall, bus_req, win_d ? inst_req : 1'b0, win_d ? 1'b0 : data_req);
        else n_pass++;
        // Next cycle is IDLE again: winner has moved on, loser still held.
        step;
        if (win_d) data_req = 1'b0;
        else       inst_req = 1'b0;
        #1;
        n_checks++;
        if (bus_req !== 1'b0 || inst_stall !== inst_req || data_stall !== data_req)
            $display("FAIL after_done: bus_req=%b stalls=%b%b, required 0 %b%b",
                     bus_req, inst_stall, data_stall, inst_req, data_req);
        else n_pass++;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        inst_req = 1'b0; data_req = 1'b0; data_wr = 1'b0; data_wen = 4'h0;
        inst_addr = '0; data_addr = '0; data_wdata = 32'h0;
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'h0;
        model_reset();
        #2;
        n_checks++;
        if ({bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata, inst_rdata, data_rdata} !== '0)
            $display("FAIL reset_outputs: bus_req=%b addr=%h irdata=%h drdata=%h, required zeros",
                     bus_req, bus_addr, inst_rdata, data_rdata);
        else n_pass++;
        inst_req = 1'b1;
        #1;
        n_checks++;
        if (inst_stall !== 1'b1 || data_stall !== 1'b0)
            $display("FAIL reset_stall: stalls=%b%b, required 10", inst_stall, data_stall);
        else n_pass++;
        step;
        step;
        inst_req = 1'b0;
        rst = 1'b1;
    endtask

    task automatic test_single_fetch;
        do_txn(1'b1, 1'b0, 1'b0, 32'hBFC0_0000, 32'h0, 32'h0, 32'h3C08_BFAF, 4'h0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_tie;
        do_txn(1'b1, 1'b1, 1'b0, $urandom, $urandom, $urandom, $urandom, 4'hF, 0, 1, 1'b0, 1'b0);
        do_txn(1'b1, 1'b1, 1'b0, $urandom, $urandom, $urandom, $urandom, 4'hF, 1, 0, 1'b0, 1'b0);
        do_txn(1'b0, 1'b0, 1'b0, $urandom, $urandom, $urandom, $urandom, 4'h0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_store;
        do_txn(1'b0, 1'b1, 1'b1, 32'h0, 32'h8000_0010, 32'h1234_ABCD, 32'hDEAD_BEEF, 4'b0011,
               4, 1, 1'b0, 1'b0);
    endtask

    task automatic test_spurious;
        do_txn(1'b0, 1'b1, 1'b0, 32'h0, $urandom, $urandom, $urandom, 4'hF, 2, 2, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid_wait;
        inst_req  = 1'b1;
        inst_addr = $urandom;
        step;
        bus_addr_ok = 1'b1;
        step;
        bus_addr_ok = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        n_checks++;
        if (bus_req !== 1'b0 || bus_addr !== '0 || inst_rdata !== 32'h0 || data_rdata !== 32'h0
            || inst_stall !== 1'b1)
            $display("FAIL reset_in_wait: bus_req=%b addr=%h irdata=%h drdata=%h istall=%b, required 0 0 0 0 1",
                     bus_req, bus_addr, inst_rdata, data_rdata, inst_stall);
        else n_pass++;
        model_reset();
        step;
        rst = 1'b1;
        inst_req = 1'b0;
        bus_data_ok = 1'b1;
        bus_rdata = $urandom;
        step;
        bus_data_ok = 1'b0;
        #1;
        n_checks++;
        if (inst_rdata !== 32'h0 || bus_req !== 1'b0)
            $display("FAIL late_data_ok: irdata=%h bus_req=%b, required 0 0", inst_rdata, bus_req);
        else n_pass++;
        do_txn(1'b1, 1'b0, 1'b0, $urandom, 32'h0, 32'h0, $urandom, 4'h0, 1, 1, 1'b0, 1'b0);
    endtask

    task automatic test_drop;
        do_txn(1'b1, 1'b0, 1'b0, $urandom, 32'h0, 32'h0, $urandom, 4'h0, 0, 2, 1'b0, 1'b1);
    endtask

    task automatic test_random;
        bit ir, dr;
        for (int n = 0; n < 40; n++) begin
            ir = 1'($urandom);
            dr = 1'($urandom);
            if (!ir && !dr && !inst_req && !data_req) ir = 1'b1;
            do_txn(ir, dr, 1'($urandom), $urandom, $urandom, $urandom, $urandom, 4'($urandom),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   1'($urandom), 1'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_tie();
        test_store();
        test_spurious();
        test_reset_mid_wait();
        test_drop();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
